// File: rtl/division_arbiter.sv
// division_arbiter: shares one multi-cycle unsigned 32-bit divider between two
// requesters. Requests arrive over valid/ready, winners alternate round-robin,
// and each result goes back on the winner's response channel. Only one
// division is in flight at a time. Divide-by-zero is answered locally and the
// divider is not started.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; the combinational ready goes to the granted requester
// ISSUE | one-cycle div_start pulse, wait counter loaded
// WAIT  | counting down the divider latency, capture q/r at zero
// RESP  | owner's response valid, held until resp_ready
module division_arbiter #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_q,
  output logic [31:0] resp0_r,
  output logic        resp0_dbz,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_q,
  output logic [31:0] resp1_r,
  output logic        resp1_dbz,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Counting starts in the cycle after the start pulse, so the last count
  // lands exactly DIV_CYCLES cycles after div_start.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             accept;
  logic             sel;
  logic [31:0]      acc_a;
  logic [31:0]      acc_b;

  // Ready is only ever raised for a valid requester, so ready alone marks the accept.
  assign accept = req0_ready | req1_ready;
  assign sel    = req1_ready;
  assign acc_a  = sel ? req1_a : req0_a;
  assign acc_b  = sel ? req1_b : req0_b;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, arbitration and handshake outputs.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    div_start   = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        // Reset gating keeps ready low while reset is held with valid requests.
        if (!reset) begin
          if (req0_valid && (!req1_valid || !prio)) begin
            req0_ready = 1'b1;
            state_nxt  = (req0_b == 32'd0) ? RESP : ISSUE;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            state_nxt  = (req1_b == 32'd0) ? RESP : ISSUE;
          end
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, round-robin pointer, wait counter and per-requester results.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      div_a     <= '0;
      div_b     <= '0;
      resp0_q   <= '0;
      resp0_r   <= '0;
      resp0_dbz <= 1'b0;
      resp1_q   <= '0;
      resp1_r   <= '0;
      resp1_dbz <= 1'b0;
    end else begin
      if (accept) begin
        owner <= sel;
        prio  <= ~sel;
        div_a <= acc_a;
        div_b <= acc_b;
        if (acc_b == 32'd0) begin
          if (sel) begin
            resp1_q   <= '1;
            resp1_r   <= acc_a;
            resp1_dbz <= 1'b1;
          end else begin
            resp0_q   <= '1;
            resp0_r   <= acc_a;
            resp0_dbz <= 1'b1;
          end
        end
      end
      if (state == ISSUE)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (capture) begin
        if (owner) begin
          resp1_q   <= div_q;
          resp1_r   <= div_r;
          resp1_dbz <= 1'b0;
        end else begin
          resp0_q   <= div_q;
          resp0_r   <= div_r;
          resp0_dbz <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_division_arbiter.sv
// Bench for division_arbiter: a behavioural divider with a fixed latency
// (random junk on q/r until the result is due), directed scenarios and a
// randomized two-requester run checked against a reference scoreboard.
module tb_division_arbiter;
  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic        resp0_dbz, resp1_dbz, div_start;
  logic [31:0] resp0_q, resp0_r, resp1_q, resp1_r, div_a, div_b, div_q, div_r;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_prio = 0;

  typedef struct { logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic [31:0] q; logic [31:0] r; logic dbz; } rsp_t;

  req_t pend0[$], pend1[$];
  rsp_t exp0[$], exp1[$];
  int   grant_log[$];

  division_arbiter #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_q(resp0_q),
    .resp0_r(resp0_r), .resp0_dbz(resp0_dbz),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_q(resp1_q),
    .resp1_r(resp1_r), .resp1_dbz(resp1_dbz),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural divider: result appears DIV_CYCLES cycles after the start pulse.
  logic [31:0] m_a = '0, m_b = '0, junk = '0;
  int          m_k = 0;
  logic        m_busy = 1'b0;
  always @(posedge clock) begin
    junk <= $urandom;
    if (reset) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (div_start) begin
      m_a    <= div_a;
      m_b    <= div_b;
      m_k    <= 0;
      m_busy <= 1'b1;
    end else if (m_busy && m_k < DIV_CYCLES) begin
      m_k <= m_k + 1;
    end
  end
  wire div_done = m_busy && (m_k >= DIV_CYCLES - 1);
  assign div_q = !div_done ? junk : ((m_b == 0) ? 32'hFFFFFFFF : m_a / m_b);
  assign div_r = !div_done ? junk : ((m_b == 0) ? m_a : m_a % m_b);

  int starts = 0;
  int last_start = -1;
  always @(negedge clock) begin
    if (div_start === 1'b1) begin
      starts = starts + 1;
      last_start = cyc;
    end
  end

  function automatic rsp_t ref_div(logic [31:0] a, logic [31:0] b);
    rsp_t e;
    if (b == 0) begin e.q = 32'hFFFFFFFF; e.r = a; e.dbz = 1'b1; end
    else begin e.q = a / b; e.r = a % b; e.dbz = 1'b0; end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_prio = 0;
  endtask

  // Offers one request and returns after the accepting edge.
  task automatic send(input int g, input logic [31:0] a, input logic [31:0] b,
                      output bit ok, output int acc);
    ok = 0; acc = -1;
    @(negedge clock);
    if (g == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (((g == 0) ? req0_ready : req1_ready) === 1'b1) begin
        ok = 1; acc = cyc; m_prio = 1 - g;
      end else begin
        @(negedge clock);
      end
    end
    @(posedge clock);
    #1;
    if (g == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Waits for a response with ready held high and returns after the handshake.
  task automatic recv(input int g, input int bound, output bit ok, output int vcyc,
                      output logic [31:0] q, output logic [31:0] r, output logic dbz);
    ok = 0; vcyc = -1; q = '0; r = '0; dbz = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clock);
      if (g == 0) resp0_ready = 1; else resp1_ready = 1;
      #1;
      if (((g == 0) ? resp0_valid : resp1_valid) === 1'b1) begin
        ok = 1; vcyc = cyc;
        q   = (g == 0) ? resp0_q : resp1_q;
        r   = (g == 0) ? resp0_r : resp1_r;
        dbz = (g == 0) ? resp0_dbz : resp1_dbz;
      end
    end
    if (ok) @(posedge clock);
    #1;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  // Drives the pending queues of both requesters until all responses return.
  task automatic run_engine(input bit rand_ready, input int bound);
    bit   done, held0, held1, a0, a1;
    int   g, eg;
    req_t x;
    rsp_t e, h0, h1;
    done = 0; held0 = 0; held1 = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clock);
      if (pend0.size() == 0 && pend1.size() == 0 && exp0.size() == 0 &&
          exp1.size() == 0 && !resp0_valid && !resp1_valid) begin
        done = 1;
      end else begin
        req0_valid = (pend0.size() > 0);
        if (req0_valid) begin req0_a = pend0[0].a; req0_b = pend0[0].b; end
        req1_valid = (pend1.size() > 0);
        if (req1_valid) begin req1_a = pend1[0].a; req1_b = pend1[0].b; end
        resp0_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        resp1_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        if (a0 || a1) begin
          checks++;
          if (a0 && a1) begin
            errors++;
            $display("FAIL dual_grant got both readies exp one");
          end else begin
            g  = a1 ? 1 : 0;
            eg = (req0_valid && req1_valid) ? m_prio : (req1_valid ? 1 : 0);
            if (g != eg) begin
              errors++;
              $display("FAIL rr_grant got=%0d exp=%0d at cyc %0d", g, eg, cyc);
            end
            m_prio = 1 - g;
            grant_log.push_back(g);
            if (g == 0) begin x = pend0.pop_front(); exp0.push_back(ref_div(x.a, x.b)); end
            else        begin x = pend1.pop_front(); exp1.push_back(ref_div(x.a, x.b)); end
          end
        end
        if (resp0_valid) begin
          if (held0) begin
            checks++;
            if (resp0_q !== h0.q || resp0_r !== h0.r || resp0_dbz !== h0.dbz) begin
              errors++;
              $display("FAIL resp0_stable got=%h/%h exp=%h/%h", resp0_q, resp0_r, h0.q, h0.r);
            end
          end
          if (resp0_ready) begin
            checks++;
            if (exp0.size() == 0) begin
              errors++;
              $display("FAIL resp0_spurious got q=%h exp no response", resp0_q);
            end else begin
              e = exp0.pop_front();
              if (resp0_q !== e.q || resp0_r !== e.r || resp0_dbz !== e.dbz) begin
                errors++;
                $display("FAIL resp0_data got=%h/%h/%b exp=%h/%h/%b",
                         resp0_q, resp0_r, resp0_dbz, e.q, e.r, e.dbz);
              end
            end
            held0 = 0;
          end else begin
            held0 = 1; h0.q = resp0_q; h0.r = resp0_r; h0.dbz = resp0_dbz;
          end
        end else held0 = 0;
        if (resp1_valid) begin
          if (held1) begin
            checks++;
            if (resp1_q !== h1.q || resp1_r !== h1.r || resp1_dbz !== h1.dbz) begin
              errors++;
              $display("FAIL resp1_stable got=%h/%h exp=%h/%h", resp1_q, resp1_r, h1.q, h1.r);
            end
          end
          if (resp1_ready) begin
            checks++;
            if (exp1.size() == 0) begin
              errors++;
              $display("FAIL resp1_spurious got q=%h exp no response", resp1_q);
            end else begin
              e = exp1.pop_front();
              if (resp1_q !== e.q || resp1_r !== e.r || resp1_dbz !== e.dbz) begin
                errors++;
                $display("FAIL resp1_data got=%h/%h/%b exp=%h/%h/%b",
                         resp1_q, resp1_r, resp1_dbz, e.q, e.r, e.dbz);
              end
            end
            held1 = 0;
          end else begin
            held1 = 1; h1.q = resp1_q; h1.r = resp1_r; h1.dbz = resp1_dbz;
          end
        end else held1 = 0;
      end
    end
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL engine_timeout got pending=%0d/%0d exp 0/0",
               pend0.size() + exp0.size(), pend1.size() + exp1.size());
      pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    req0_valid = 1; req0_a = 32'd11; req0_b = 32'd3;
    req1_valid = 1; req1_a = 32'd12; req1_b = 32'd0;
    resp0_ready = 1; resp1_ready = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_dbz, resp1_dbz, div_start} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_dbz, resp1_dbz, div_start});
    end
    checks++;
    if ({div_a, div_b, resp0_q, resp0_r, resp1_q, resp1_r} !== 192'b0) begin
      errors++;
      $display("FAIL reset_data got div_a=%h div_b=%h q0=%h r0=%h q1=%h r1=%h exp all 0",
               div_a, div_b, resp0_q, resp0_r, resp1_q, resp1_r);
    end
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    reset = 1'b0;
    m_prio = 0;
  endtask

  task automatic test_single();
    bit ok; int acc, vc, s0; logic [31:0] q, r; logic dbz;
    s0 = starts;
    send(0, 32'd100, 32'd7, ok, acc);
    recv(0, 200, ok, vc, q, r, dbz);
    checks++;
    if (starts != s0 + 1 || last_start != acc + 1) begin
      errors++;
      $display("FAIL single_start got cyc=%0d n=%0d exp cyc=%0d n=1", last_start, starts - s0, acc + 1);
    end
    checks++;
    if (!ok || vc != acc + 2 + DIV_CYCLES) begin
      errors++;
      $display("FAIL single_latency got=%0d exp=%0d", vc, acc + 2 + DIV_CYCLES);
    end
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL single_data got=%0d/%0d/%b exp=14/2/0", q, r, dbz);
    end
    checks++;
    if (div_a !== 32'd100 || div_b !== 32'd7) begin
      errors++;
      $display("FAIL single_operand_hold got=%0d/%0d exp=100/7", div_a, div_b);
    end
  endtask

  task automatic test_contention();
    int exp_g[6];
    exp_g = '{0, 1, 0, 1, 0, 1};
    do_reset();
    grant_log.delete();
    pend0.push_back('{32'd50, 32'd5});
    pend0.push_back('{32'd81, 32'd9});
    pend0.push_back('{32'd1000, 32'd7});
    pend1.push_back('{32'd9, 32'd4});
    pend1.push_back('{32'd6, 32'd0});
    pend1.push_back('{32'd123456, 32'd1000});
    run_engine(1'b0, 2000);
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL contention_count got=%0d exp=6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_g[i]) begin
          errors++;
          $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, grant_log[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_dbz();
    bit ok; int acc, vc, s0; logic [31:0] q, r; logic dbz;
    s0 = starts;
    send(1, 32'd1234, 32'd0, ok, acc);
    recv(1, 100, ok, vc, q, r, dbz);
    checks++;
    if (!ok || vc != acc + 1) begin
      errors++;
      $display("FAIL dbz_latency got=%0d exp=%0d", vc, acc + 1);
    end
    checks++;
    if (q !== 32'hFFFFFFFF || r !== 32'd1234 || dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_data got=%h/%0d/%b exp=ffffffff/1234/1", q, r, dbz);
    end
    checks++;
    if (starts != s0) begin
      errors++;
      $display("FAIL dbz_no_start got=%0d exp=0", starts - s0);
    end
  endtask

  task automatic test_backpressure();
    bit ok, found; int acc, vc, rel; logic [31:0] q0, r0, q, r; logic dbz;
    send(0, 32'd1000, 32'd3, ok, acc);
    @(negedge clock);
    req1_valid = 1; req1_a = 32'd5; req1_b = 32'd1;
    resp0_ready = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      #1;
      if (resp0_valid === 1'b1) found = 1;
      else @(negedge clock);
    end
    q0 = resp0_q; r0 = resp0_r;
    checks++;
    if (!found || q0 !== 32'd333 || r0 !== 32'd1) begin
      errors++;
      $display("FAIL bp_first got valid=%b %0d/%0d exp 1 333/1", found, q0, r0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      checks++;
      if (resp0_valid !== 1'b1 || resp0_q !== q0 || resp0_r !== r0 ||
          req1_ready !== 1'b0 || resp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b q=%h r=%h rdy1=%b v1=%b exp 1 %h %h 0 0",
                 i, resp0_valid, resp0_q, resp0_r, req1_ready, resp1_valid, q0, r0);
      end
    end
    @(negedge clock);
    resp0_ready = 1;
    #1 rel = cyc;
    @(posedge clock);
    #1 resp0_ready = 0;
    @(negedge clock);
    #1;
    checks++;
    if (resp0_valid !== 1'b0 || req1_ready !== 1'b1 || cyc != rel + 1) begin
      errors++;
      $display("FAIL bp_release got v0=%b rdy1=%b exp v0=0 rdy1=1", resp0_valid, req1_ready);
    end
    @(posedge clock);
    #1 req1_valid = 0;
    m_prio = 0;
    recv(1, 100, ok, vc, q, r, dbz);
    checks++;
    if (!ok || q !== 32'd5 || r !== 32'd0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got ok=%b %0d/%0d/%b exp 1 5/0/0", ok, q, r, dbz);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int acc, vc, seen; logic [31:0] q, r; logic dbz;
    send(1, 32'd77, 32'd8, ok, acc);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    m_prio = 0;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_dbz, resp1_dbz, div_start} !== 7'b0 ||
        {div_a, div_b, resp0_q, resp0_r, resp1_q, resp1_r} !== 192'b0) begin
      errors++;
      $display("FAIL midwait_reset got div_a=%h div_b=%h q1=%h r1=%h v1=%b exp all 0",
               div_a, div_b, resp1_q, resp1_r, resp1_valid);
    end
    seen = 0;
    resp0_ready = 1; resp1_ready = 1;
    repeat (60) begin
      @(negedge clock);
      if (resp0_valid === 1'b1 || resp1_valid === 1'b1 || div_start === 1'b1) seen++;
    end
    resp0_ready = 0; resp1_ready = 0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midwait_quiet got=%0d active cycles exp=0", seen);
    end
    send(0, 32'd7, 32'd7, ok, acc);
    recv(0, 200, ok, vc, q, r, dbz);
    checks++;
    if (!ok || q !== 32'd1 || r !== 32'd0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL midwait_after got ok=%b %0d/%0d/%b exp 1 1/0/0", ok, q, r, dbz);
    end
  endtask

  task automatic test_boundary();
    bit ok; int acc, vc; logic [31:0] q, r; logic dbz;
    send(0, 32'hFFFFFFFF, 32'd1, ok, acc);
    recv(0, 200, ok, vc, q, r, dbz);
    checks++;
    if (!ok || q !== 32'hFFFFFFFF || r !== 32'd0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL bound_max_a got=%h/%h/%b exp=ffffffff/0/0", q, r, dbz);
    end
    send(1, 32'd3, 32'hFFFFFFFF, ok, acc);
    recv(1, 200, ok, vc, q, r, dbz);
    checks++;
    if (!ok || q !== 32'd0 || r !== 32'd3 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL bound_max_b got=%h/%h/%b exp=0/3/0", q, r, dbz);
    end
  endtask

  task automatic test_random();
    req_t x;
    int n0;
    n0 = grant_log.size();
    for (int i = 0; i < 20; i++) begin
      x.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 5))
        0:       x.b = 32'd0;
        1:       x.b = 32'hFFFFFFFF;
        2, 3:    x.b = 32'($urandom_range(1, 15));
        default: x.b = $urandom | 32'd1;
      endcase
      if (i % 2 == 0) pend0.push_back(x); else pend1.push_back(x);
    end
    run_engine(1'b1, 5000);
    checks++;
    if (grant_log.size() - n0 != 20) begin
      errors++;
      $display("FAIL random_count got=%0d exp=20", grant_log.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_dbz();
    test_backpressure();
    test_reset_mid_wait();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
